// File: rtl/cla_pkg.sv
// cla_pkg: shared constants and helpers for the pipelined carry-lookahead adder.
//   CLA_WIDTH / CLA_GROUP : default operand width and lookahead group size
//   cla_num_groups()      : pipeline depth NG = WIDTH / GROUP (1 for degenerate sizes)
//   pg_t, cla_pg()        : per-bit propagate / generate pair
//   cla_pg_merge()        : combine a higher (p,g) span with a lower one
package cla_pkg;

  localparam int unsigned CLA_WIDTH = 16;
  localparam int unsigned CLA_GROUP = 4;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  // Degenerate sizes return 1 so array declarations stay legal while the
  // elaboration check in the top reports the bad configuration.
  function automatic int unsigned cla_num_groups(input int unsigned width,
                                                 input int unsigned group);
    if (group == 0) return 1;
    if ((width / group) == 0) return 1;
    return width / group;
  endfunction

  // Propagate is the XOR form so it doubles as the half-sum for the sum bit.
  function automatic pg_t cla_pg(input logic a, input logic b);
    pg_t r;
    r.p = a ^ b;
    r.g = a & b;
    return r;
  endfunction

  function automatic pg_t cla_pg_merge(input pg_t hi, input pg_t lo);
    pg_t r;
    r.p = hi.p & lo.p;
    r.g = hi.g | (hi.p & lo.g);
    return r;
  endfunction

endpackage

// File: rtl/cla_group.sv
// cla_group: combinational GROUP-bit carry-lookahead block.
//   a_i, b_i : group operand bits
//   c_i      : carry into the group
//   s_o      : group sum bits
//   c_o      : carry out of the group
// Every internal carry is formed from the prefix (P,G) of the bits below it
// and c_i directly, so no carry ripples from bit to bit.
module cla_group
  import cla_pkg::*;
#(
  parameter int unsigned GROUP = CLA_GROUP
) (
  input  logic [GROUP-1:0] a_i,
  input  logic [GROUP-1:0] b_i,
  input  logic             c_i,
  output logic [GROUP-1:0] s_o,
  output logic             c_o
);

  pg_t             pg  [GROUP];
  pg_t             acc;
  logic [GROUP:0]  c;

  always_comb begin
    for (int i = 0; i < GROUP; i++) pg[i] = cla_pg(a_i[i], b_i[i]);
    c    = '0;
    c[0] = c_i;
    acc  = '{p: 1'b1, g: 1'b0};
    for (int i = 0; i < GROUP; i++) begin
      acc      = cla_pg_merge(pg[i], acc);
      c[i + 1] = acc.g | (acc.p & c_i);
    end
    s_o = '0;
    for (int i = 0; i < GROUP; i++) s_o[i] = pg[i].p ^ c[i];
    c_o = c[GROUP];
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: WIDTH-bit adder/subtractor built from NG = WIDTH/GROUP
// carry-lookahead groups, one group resolved per pipeline stage.
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready is combinational, never
//                         depends on in_valid)
//   a, b, cin, sub      : operands; sub=1 computes a + ~b + ~cin = a - b - cin
//   out_valid/out_ready : result handshake
//   sum, cout           : result and carry-out (NOT borrow when subtracting)
//   ovf                 : signed overflow, only when CLA_OVF_FLAG_EN is defined
// Optional feature macro: CLA_OVF_FLAG_EN adds the ovf port and its register.
// Latency is NG cycles; one global advance enable stalls every stage together.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = CLA_WIDTH,
  parameter int unsigned GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NG = cla_num_groups(WIDTH, GROUP);

  if (GROUP < 1) begin : g_chk_group
    $error("pipelined_cla_adder: GROUP must be at least 1");
  end else if ((WIDTH % GROUP) != 0) begin : g_chk_width
    $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP");
  end

  logic adv;

  // Stage register outputs, indexed by stage; element k feeds stage k+1.
  logic [WIDTH-1:0] stg_a   [NG];
  logic [WIDTH-1:0] stg_b   [NG];
  logic [WIDTH-1:0] stg_sum [NG];
  logic             stg_c   [NG];
  logic             stg_vld [NG];

  assign out_valid = stg_vld[NG-1];
  assign sum       = stg_sum[NG-1];
  assign cout      = stg_c[NG-1];
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;

  for (genvar k = 0; k < NG; k++) begin : g_stage
    localparam logic [WIDTH-1:0] GMASK =
      ((WIDTH'(1) << GROUP) - WIDTH'(1)) << (k * GROUP);

    logic [WIDTH-1:0] a_s, b_s, sum_s, sum_d;
    logic             c_s, vld_s;
    logic [GROUP-1:0] gsum;
    logic             gco;

    // Stage k input: stage 0 takes the ports (b and cin inverted for
    // subtraction), later stages take the previous stage's registers.
    if (k == 0) begin : g_src
      assign a_s   = a;
      assign b_s   = sub ? ~b : b;
      assign c_s   = cin ^ sub;
      assign sum_s = '0;
      assign vld_s = in_valid;
    end else begin : g_src
      assign a_s   = stg_a[k-1];
      assign b_s   = stg_b[k-1];
      assign sum_s = stg_sum[k-1];
      assign c_s   = stg_c[k-1];
      assign vld_s = stg_vld[k-1];
    end

    cla_group #(
      .GROUP (GROUP)
    ) u_grp (
      .a_i (GROUP'(a_s >> (k * GROUP))),
      .b_i (GROUP'(b_s >> (k * GROUP))),
      .c_i (c_s),
      .s_o (gsum),
      .c_o (gco)
    );

    // Lower groups already resolved pass through; this group's bits are merged in.
    always_comb begin
      sum_d = (sum_s & ~GMASK) | (WIDTH'(gsum) << (k * GROUP));
    end

    // Stage k register boundary.
    if (k < NG - 1) begin : g_reg
      logic [WIDTH-1:0] a_q, b_q, sum_q;
      logic             c_q, vld_q;

      always_ff @(posedge clk) begin
        if (rst) vld_q <= 1'b0;
        else if (adv) vld_q <= vld_s;
      end

      always_ff @(posedge clk) begin
        if (adv) begin
          a_q   <= a_s;
          b_q   <= b_s;
          sum_q <= sum_d;
          c_q   <= gco;
        end
      end

      assign stg_a[k]   = a_q;
      assign stg_b[k]   = b_q;
      assign stg_sum[k] = sum_q;
      assign stg_c[k]   = c_q;
      assign stg_vld[k] = vld_q;
    end else begin : g_reg
      // Output stage: result registers are architecturally visible, so they reset.
      logic [WIDTH-1:0] sum_q;
      logic             c_q, vld_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= 1'b0;
          sum_q <= '0;
          c_q   <= 1'b0;
        end else if (adv) begin
          vld_q <= vld_s;
          sum_q <= sum_d;
          c_q   <= gco;
        end
      end

      assign stg_a[k]   = '0;
      assign stg_b[k]   = '0;
      assign stg_sum[k] = sum_q;
      assign stg_c[k]   = c_q;
      assign stg_vld[k] = vld_q;

`ifdef CLA_OVF_FLAG_EN
      logic ovf_d, ovf_q;

      // Operand MSBs reach this stage through the skew registers.
      assign ovf_d = (a_s[WIDTH-1] == b_s[WIDTH-1]) & (sum_d[WIDTH-1] != a_s[WIDTH-1]);

      always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else if (adv) ovf_q <= ovf_d;
      end

      assign ovf = ovf_q;
`endif
    end
  end

endmodule
